// File: rtl/soft_rst_ctrl.sv
// soft_rst_ctrl: reset-request controller in the clk_sys domain.
// Accepts a keyed host reset command or a detected PLL lock-loss event,
// drives soft_rst_en into the reset generator for a fixed pulse, then
// follows the generator's rst_n feedback through assert and release
// before a hold-off period. Only one request is in flight at a time.
//
// Ports:
//   clk_sys      in   sole clock
//   rst          in   asynchronous active-high reset
//   cmd_rst_req  in   single-cycle host reset command strobe
//   cmd_rst_key  in   16-bit key, must be 16'hA55A with cmd_rst_req
//   pll_locked   in   PLL lock, asynchronous (2-FF synchronised)
//   rst_n_fb     in   system rst_n feedback, asynchronous (2-FF synchronised)
//   soft_rst_en  out  reset request to the reset generator
//   rst_busy     out  high whenever a request is in progress
//   rst_cause    out  last accepted cause: 01 command, 10 lock loss
//   rst_cnt      out  accepted request count, saturating at 255
//   ack_timeout  out  sticky flag: feedback never went low in time
module soft_rst_ctrl #(
    parameter int unsigned U_DLY         = 1,
    parameter string       SIMULATION    = "FALSE",
    parameter int unsigned PULSE_CYC     = 16,
    parameter int unsigned ACK_TO_CYC    = 65535,
    parameter int unsigned HOLDOFF_CYC   = 1024,
    parameter int unsigned LOCK_LOSS_CYC = 8
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic        cmd_rst_req,
    input  logic [15:0] cmd_rst_key,
    input  logic        pll_locked,
    input  logic        rst_n_fb,
    output logic        soft_rst_en,
    output logic        rst_busy,
    output logic [1:0]  rst_cause,
    output logic [7:0]  rst_cnt,
    output logic        ack_timeout
);

    localparam int unsigned CYC_W = 16;
    localparam int unsigned CNT_W = 8;

    // Simulation builds shorten the long waits so tests stay fast
    localparam bit          SIM_MODE   = (SIMULATION == "TRUE");
    localparam int unsigned ACK_TO_EFF = SIM_MODE ? 32'd256 : ACK_TO_CYC;
    localparam int unsigned HOLD_EFF   = SIM_MODE ? 32'd16  : HOLDOFF_CYC;

    // Terminal counts; a zero setting behaves like one cycle
    localparam logic [CYC_W-1:0] PULSE_LAST = CYC_W'((PULSE_CYC  > 0) ? PULSE_CYC  - 1 : 0);
    localparam logic [CYC_W-1:0] ACK_LAST   = CYC_W'((ACK_TO_EFF > 0) ? ACK_TO_EFF - 1 : 0);
    localparam logic [CYC_W-1:0] HOLD_LAST  = CYC_W'((HOLD_EFF   > 0) ? HOLD_EFF   - 1 : 0);
    localparam logic [CNT_W-1:0] LOCK_RUN   = CNT_W'(LOCK_LOSS_CYC);
    localparam logic [CNT_W-1:0] LOCK_LAST  = CNT_W'((LOCK_LOSS_CYC > 0) ? LOCK_LOSS_CYC - 1 : 0);

    localparam logic [15:0] CMD_KEY     = 16'hA55A;
    localparam logic [1:0]  CAUSE_CMD   = 2'b01;
    localparam logic [1:0]  CAUSE_LOCK  = 2'b10;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // U_DLY only mattered for delayed assignments in older models; RTL is zero-delay
    if (U_DLY > 0) begin : g_u_dly
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_WAIT_ACK,
        ST_WAIT_REL,
        ST_HOLDOFF
    } state_t;

    state_t           state_q, state_d;
    logic [CYC_W-1:0] cyc_q, cyc_d;
    logic             pll_s1_q, pll_s1_d, pll_s2_q, pll_s2_d;
    logic             fb_s1_q, fb_s1_d, fb_s2_q, fb_s2_d;
    logic             armed_q, armed_d;
    logic [CNT_W-1:0] low_cnt_q, low_cnt_d;
    logic             lock_evt_q, lock_evt_d;
    logic             pend_q, pend_d;
    logic             soft_rst_en_q, soft_rst_en_d;
    logic             rst_busy_q, rst_busy_d;
    logic [1:0]       rst_cause_q, rst_cause_d;
    logic [CNT_W-1:0] rst_cnt_q, rst_cnt_d;
    logic             ack_timeout_q, ack_timeout_d;
    logic             cmd_ok_c;

    // Synchronisers and lock-loss detector
    always_comb begin
        pll_s1_d   = pll_locked;
        pll_s2_d   = pll_s1_q;
        fb_s1_d    = rst_n_fb;
        fb_s2_d    = fb_s1_q;
        armed_d    = armed_q | pll_s2_q;
        low_cnt_d  = low_cnt_q;
        lock_evt_d = 1'b0;
        if (pll_s2_q) begin
            low_cnt_d = '0;
        end else if (armed_q && (low_cnt_q != LOCK_RUN)) begin
            // Counter parks at LOCK_RUN so a long low run fires only once
            low_cnt_d  = low_cnt_q + CNT_W'(1);
            lock_evt_d = (low_cnt_q == LOCK_LAST);
        end
    end

    assign cmd_ok_c = cmd_rst_req && (cmd_rst_key == CMD_KEY);

    // Request sequencer: next state and registered output values
    always_comb begin
        state_d       = state_q;
        cyc_d         = cyc_q + CYC_W'(1);
        rst_cause_d   = rst_cause_q;
        rst_cnt_d     = rst_cnt_q;
        ack_timeout_d = ack_timeout_q;
        // A lock loss outside IDLE is remembered once and serviced later
        pend_d        = pend_q | (lock_evt_q && (state_q != ST_IDLE));

        unique case (state_q)
            ST_IDLE: begin
                if (lock_evt_q || pend_q) begin
                    state_d     = ST_ASSERT;
                    rst_cause_d = CAUSE_LOCK;
                    pend_d      = 1'b0;
                    if (rst_cnt_q != CNT_MAX) rst_cnt_d = rst_cnt_q + CNT_W'(1);
                end else if (cmd_ok_c) begin
                    state_d       = ST_ASSERT;
                    rst_cause_d   = CAUSE_CMD;
                    ack_timeout_d = 1'b0;
                    if (rst_cnt_q != CNT_MAX) rst_cnt_d = rst_cnt_q + CNT_W'(1);
                end
            end
            ST_ASSERT: begin
                if (cyc_q == PULSE_LAST) state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (!fb_s2_q) begin
                    state_d = ST_WAIT_REL;
                end else if (cyc_q == ACK_LAST) begin
                    state_d       = ST_HOLDOFF;
                    ack_timeout_d = 1'b1;
                end
            end
            ST_WAIT_REL: begin
                if (fb_s2_q) state_d = ST_HOLDOFF;
            end
            ST_HOLDOFF: begin
                if (cyc_q == HOLD_LAST) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Cycle counter restarts on every state entry and idles at zero
        if ((state_d != state_q) || (state_q == ST_IDLE)) cyc_d = '0;

        soft_rst_en_d = (state_d == ST_ASSERT);
        rst_busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cyc_q         <= '0;
            pll_s1_q      <= 1'b0;
            pll_s2_q      <= 1'b0;
            fb_s1_q       <= 1'b0;
            fb_s2_q       <= 1'b0;
            armed_q       <= 1'b0;
            low_cnt_q     <= '0;
            lock_evt_q    <= 1'b0;
            pend_q        <= 1'b0;
            soft_rst_en_q <= 1'b0;
            rst_busy_q    <= 1'b0;
            rst_cause_q   <= 2'b00;
            rst_cnt_q     <= '0;
            ack_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cyc_q         <= cyc_d;
            pll_s1_q      <= pll_s1_d;
            pll_s2_q      <= pll_s2_d;
            fb_s1_q       <= fb_s1_d;
            fb_s2_q       <= fb_s2_d;
            armed_q       <= armed_d;
            low_cnt_q     <= low_cnt_d;
            lock_evt_q    <= lock_evt_d;
            pend_q        <= pend_d;
            soft_rst_en_q <= soft_rst_en_d;
            rst_busy_q    <= rst_busy_d;
            rst_cause_q   <= rst_cause_d;
            rst_cnt_q     <= rst_cnt_d;
            ack_timeout_q <= ack_timeout_d;
        end
    end

    assign soft_rst_en = soft_rst_en_q;
    assign rst_busy    = rst_busy_q;
    assign rst_cause   = rst_cause_q;
    assign rst_cnt     = rst_cnt_q;
    assign ack_timeout = ack_timeout_q;

endmodule

// File: tb/tb_soft_rst_ctrl.sv
`timescale 1ns/1ps
module tb_soft_rst_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic        rst, cmd_rst_req, pll_locked, rst_n_fb;
    logic [15:0] cmd_rst_key;
    logic        soft_rst_en, rst_busy, ack_timeout;
    logic [1:0]  rst_cause;
    logic [7:0]  rst_cnt;

    // SIMULATION="TRUE" instance (short ack timeout and hold-off)
    logic        s_rst, s_req, s_pll, s_fb, s_hold;
    logic [15:0] s_key;
    logic        s_en, s_busy, s_to;
    logic [1:0]  s_cause;
    logic [7:0]  s_cnt;

    soft_rst_ctrl u_dut (
        .clk_sys     (clk),
        .rst         (rst),
        .cmd_rst_req (cmd_rst_req),
        .cmd_rst_key (cmd_rst_key),
        .pll_locked  (pll_locked),
        .rst_n_fb    (rst_n_fb),
        .soft_rst_en (soft_rst_en),
        .rst_busy    (rst_busy),
        .rst_cause   (rst_cause),
        .rst_cnt     (rst_cnt),
        .ack_timeout (ack_timeout)
    );

    soft_rst_ctrl #(.SIMULATION("TRUE")) u_sim (
        .clk_sys     (clk),
        .rst         (s_rst),
        .cmd_rst_req (s_req),
        .cmd_rst_key (s_key),
        .pll_locked  (s_pll),
        .rst_n_fb    (s_fb),
        .soft_rst_en (s_en),
        .rst_busy    (s_busy),
        .rst_cause   (s_cause),
        .rst_cnt     (s_cnt),
        .ack_timeout (s_to)
    );

    // Simple reset-generator model for the short instance: rst_n low while
    // the request is high, unless held high to provoke a timeout
    always @(negedge clk) s_fb = s_hold ? 1'b1 : ~s_en;

    localparam logic [15:0] KEY = 16'hA55A;

    typedef struct {
        logic        req;
        logic [15:0] key;
        logic        en;
        logic        busy;
        logic [1:0]  cause;
        logic [7:0]  cnt;
    } vec_t;

    vec_t tbl [8];
    int   n_vec  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Finish a default-instance request: wait pulse end, pulse rst_n_fb, wait idle
    task automatic handshake(input string tag);
        int n;
        n = 0;
        while (soft_rst_en && n < 40) begin @(negedge clk); n++; end
        chk({tag, "_en_fall"}, 32'(soft_rst_en), 32'd0);
        rst_n_fb = 1'b0;
        repeat (6) @(negedge clk);
        rst_n_fb = 1'b1;
        n = 0;
        while (rst_busy && n < 1200) begin @(negedge clk); n++; end
        chk({tag, "_idle"}, 32'(rst_busy), 32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got running, want done");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, c_en, c_ack, c_hold, stall;
        logic seen;

        tbl[0] = '{1'b0, 16'h0000, 1'b0, 1'b0, 2'b00, 8'd0};
        tbl[1] = '{1'b1, 16'h1234, 1'b0, 1'b0, 2'b00, 8'd0};
        tbl[2] = '{1'b1, 16'hA55B, 1'b0, 1'b0, 2'b00, 8'd0};
        tbl[3] = '{1'b1, 16'h5AA5, 1'b0, 1'b0, 2'b00, 8'd0};
        tbl[4] = '{1'b1, 16'hA55A, 1'b1, 1'b1, 2'b01, 8'd1};
        tbl[5] = '{1'b1, 16'hA55A, 1'b1, 1'b1, 2'b01, 8'd1};
        tbl[6] = '{1'b0, 16'h0000, 1'b1, 1'b1, 2'b01, 8'd1};
        tbl[7] = '{1'b1, 16'h1234, 1'b1, 1'b1, 2'b01, 8'd1};

        rst = 1'b1; cmd_rst_req = 1'b0; cmd_rst_key = '0; pll_locked = 1'b0; rst_n_fb = 1'b1;
        s_rst = 1'b1; s_req = 1'b0; s_key = KEY; s_pll = 1'b0; s_hold = 1'b1;
        repeat (3) @(negedge clk);
        chk("in_reset_en", 32'(soft_rst_en), 32'd0);
        chk("in_reset_busy", 32'(rst_busy), 32'd0);
        rst = 1'b0; s_rst = 1'b0;

        // PLL never locked: detector stays disarmed
        repeat (30) @(negedge clk);
        chk("nolock_en", 32'(soft_rst_en), 32'd0);
        chk("nolock_busy", 32'(rst_busy), 32'd0);
        chk("reset_cause", 32'(rst_cause), 32'd0);
        chk("reset_cnt", 32'(rst_cnt), 32'd0);
        chk("reset_to", 32'(ack_timeout), 32'd0);

        pll_locked = 1'b1;
        repeat (5) @(negedge clk);

        // Key filtering and command acceptance, one vector per cycle
        for (int i = 0; i < 8; i++) begin
            cmd_rst_req = tbl[i].req;
            cmd_rst_key = tbl[i].key;
            @(negedge clk);
            chk($sformatf("vec%0d_en", i),    32'(soft_rst_en), 32'(tbl[i].en));
            chk($sformatf("vec%0d_busy", i),  32'(rst_busy),    32'(tbl[i].busy));
            chk($sformatf("vec%0d_cause", i), 32'(rst_cause),   32'(tbl[i].cause));
            chk($sformatf("vec%0d_cnt", i),   32'(rst_cnt),     32'(tbl[i].cnt));
        end
        cmd_rst_req = 1'b0;

        // 4 pulse cycles seen in the table, 12 more expected
        n = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            if (!soft_rst_en) break;
            n++;
        end
        chk("pulse_rest", 32'(n), 32'd12);

        rst_n_fb = 1'b0;
        repeat (6) @(negedge clk);
        chk("wait_rel_busy", 32'(rst_busy), 32'd1);
        chk("wait_rel_en", 32'(soft_rst_en), 32'd0);
        rst_n_fb = 1'b1;
        // 2 sync cycles + 1024 hold-off; a valid command mid hold-off is dropped
        n = 0;
        for (int j = 0; j < 1200; j++) begin
            @(negedge clk);
            if (j == 100) begin cmd_rst_req = 1'b1; cmd_rst_key = KEY; end
            if (j == 101) cmd_rst_req = 1'b0;
            if (!rst_busy) break;
            n++;
        end
        chk("holdoff_len", 32'(n), 32'd1026);
        chk("holdoff_cnt", 32'(rst_cnt), 32'd1);
        chk("holdoff_cause", 32'(rst_cause), 32'd1);
        chk("holdoff_to", 32'(ack_timeout), 32'd0);

        // 7-sample lock glitch: no request
        seen = 1'b0;
        pll_locked = 1'b0;
        repeat (7) begin @(negedge clk); seen |= rst_busy; end
        pll_locked = 1'b1;
        repeat (25) begin @(negedge clk); seen |= rst_busy; end
        chk("glitch_no_req", 32'(seen), 32'd0);
        chk("glitch_cnt", 32'(rst_cnt), 32'd1);

        // Sustained lock loss: request LOCK_LOSS_CYC+3 samples after drive
        pll_locked = 1'b0;
        n = 0;
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            n++;
            if (soft_rst_en) break;
        end
        chk("lockloss_latency", 32'(n), 32'd11);
        chk("lockloss_cause", 32'(rst_cause), 32'd2);
        chk("lockloss_cnt", 32'(rst_cnt), 32'd2);
        pll_locked = 1'b1;

        // Lock loss during WAIT_REL is held pending and serviced after hold-off
        n = 0;
        while (soft_rst_en && n < 40) begin @(negedge clk); n++; end
        rst_n_fb = 1'b0;
        repeat (6) @(negedge clk);
        pll_locked = 1'b0;
        repeat (12) @(negedge clk);
        pll_locked = 1'b1;
        repeat (3) @(negedge clk);
        chk("pend_still_busy", 32'(rst_busy), 32'd1);
        chk("pend_cnt_hold", 32'(rst_cnt), 32'd2);
        rst_n_fb = 1'b1;
        n = 0;
        while (rst_busy && n < 1200) begin @(negedge clk); n++; end
        chk("pend_idle", 32'(rst_busy), 32'd0);
        @(negedge clk);
        chk("pend_service_en", 32'(soft_rst_en), 32'd1);
        chk("pend_cause", 32'(rst_cause), 32'd2);
        chk("pend_cnt", 32'(rst_cnt), 32'd3);
        handshake("pend");

        // Command and lock-loss event in the same cycle: lock loss wins
        pll_locked = 1'b0;
        repeat (10) @(negedge clk);
        cmd_rst_req = 1'b1; cmd_rst_key = KEY;
        @(negedge clk);
        cmd_rst_req = 1'b0;
        chk("simul_en", 32'(soft_rst_en), 32'd1);
        chk("simul_cause", 32'(rst_cause), 32'd2);
        chk("simul_cnt", 32'(rst_cnt), 32'd4);
        pll_locked = 1'b1;
        handshake("simul");
        seen = 1'b0;
        repeat (30) begin @(negedge clk); seen |= rst_busy; end
        chk("simul_no_extra", 32'(seen), 32'd0);
        chk("simul_cnt_final", 32'(rst_cnt), 32'd4);

        // Short instance: ack timeout with feedback held high
        repeat (5) @(negedge clk);
        s_req = 1'b1;
        @(negedge clk);
        s_req = 1'b0;
        c_en = 0; c_ack = 0; c_hold = 0;
        for (int j = 0; j < 2000; j++) begin
            if (!s_busy) break;
            if (s_en) c_en++;
            else if (!s_to) c_ack++;
            else c_hold++;
            @(negedge clk);
        end
        chk("to_idle", 32'(s_busy), 32'd0);
        chk("to_pulse_len", 32'(c_en), 32'd16);
        chk("to_wait_len", 32'(c_ack), 32'd256);
        chk("to_hold_len", 32'(c_hold), 32'd16);
        chk("to_flag", 32'(s_to), 32'd1);
        chk("to_cnt", 32'(s_cnt), 32'd1);

        // Next valid command clears the sticky timeout
        s_hold = 1'b0;
        @(negedge clk);
        s_req = 1'b1;
        @(negedge clk);
        s_req = 1'b0;
        chk("to_clear", 32'(s_to), 32'd0);
        chk("to_clear_cause", 32'(s_cause), 32'd1);
        chk("to_clear_cnt", 32'(s_cnt), 32'd2);
        n = 0;
        while (s_busy && n < 200) begin @(negedge clk); n++; end
        chk("to_clear_idle", 32'(s_busy), 32'd0);

        // Asynchronous reset in the middle of ASSERT
        s_req = 1'b1;
        @(negedge clk);
        s_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_en", 32'(s_en), 32'd1);
        chk("pre_rst_cnt", 32'(s_cnt), 32'd3);
        #2 s_rst = 1'b1;
        #1;
        chk("async_rst_en", 32'(s_en), 32'd0);
        chk("async_rst_busy", 32'(s_busy), 32'd0);
        chk("async_rst_cause", 32'(s_cause), 32'd0);
        chk("async_rst_cnt", 32'(s_cnt), 32'd0);
        chk("async_rst_to", 32'(s_to), 32'd0);
        @(negedge clk);
        s_rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("post_rst_busy", 32'(s_busy), 32'd0);

        // 256 accepted commands: count saturates at 255
        stall = 0;
        for (int i = 0; i < 256; i++) begin
            s_req = 1'b1;
            @(negedge clk);
            s_req = 1'b0;
            n = 0;
            while (s_busy && n < 200) begin @(negedge clk); n++; end
            if (s_busy) stall++;
            if (i == 254) chk("cnt_255", 32'(s_cnt), 32'd255);
        end
        chk("burst_stall", 32'(stall), 32'd0);
        chk("cnt_saturate", 32'(s_cnt), 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
